regfile_sb: RTL and testbench

Parametrised integer register file with an integrated per-register busy scoreboard, used by the decode/issue stage of the core. It provides NUM_RD combinational read ports, one writeback port, and one issue port. The issue port marks a destination register busy until its writeback arrives. A global flush clears all pending marks. Register 0 reads as zero, is never written and is never busy.

---
 rtl/regfile_sb_pkg.sv | 22 ++
 rtl/regfile_rd_port.sv | 67 ++++++
 rtl/regfile_sb.sv | 123 ++++++++++++
 tb/tb_regfile_sb.sv | 373 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_sb_pkg.sv
// Purpose : shared types and constants for the integer register file / scoreboard.
// Latency : n/a (declarations only).
// Backpressure: n/a.
//
// Contents: XLEN default, architectural register address type, zero-register index.
package regfile_sb_pkg;

    // Default integer data width of the core.
    localparam int XLEN_DEFAULT = 32;

    // Architectural register address (x0..x31).
    typedef logic [4:0] reg_adr_t;

    // x0 is hardwired to zero: never stored, never written, never busy.
    localparam reg_adr_t ZERO_REG = 5'd0;

    // True when an address of any width selects the zero register.
    function automatic logic is_zero_reg(input logic [31:0] adr);
        return adr == 32'(ZERO_REG);
    endfunction

endpackage

// File: rtl/regfile_rd_port.sv
// Purpose : one combinational read port of the register file (data + busy flag).
// Latency : 0 cycles, address to data/busy.
// Backpressure: none; a read is always served.
//
// Ports:
//   rd_adr_i  - register to read
//   regs_i    - register contents, entry 0 is ignored
//   busy_i    - scoreboard bits, bit 0 is ignored
//   wb_*_i    - writeback forwarding inputs (only with REGFILE_BYPASS_EN)
//   rd_data_o - read data, zero for x0
//   rd_busy_o - busy flag of the addressed register, zero for x0
//
// Optional feature macro: REGFILE_BYPASS_EN forwards a same-cycle writeback
// to the read data and clears the reported busy flag.
module regfile_rd_port
    import regfile_sb_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int DEPTH = 32,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic [AW-1:0]   rd_adr_i,
    input  logic [XLEN-1:0] regs_i [DEPTH],
    input  logic [DEPTH-1:0] busy_i,
`ifdef REGFILE_BYPASS_EN
    input  logic            wb_v_i,
    input  logic [AW-1:0]   wb_adr_i,
    input  logic [XLEN-1:0] wb_data_i,
`endif
    output logic [XLEN-1:0] rd_data_o,
    output logic            rd_busy_o
);

    logic adr_zero;

    assign adr_zero = is_zero_reg(32'(rd_adr_i));

`ifdef REGFILE_BYPASS_EN
    // A writeback to the addressed register this cycle means the value is
    // already known: hand it over directly and report the register as ready.
    logic fwd_hit;

    assign fwd_hit = wb_v_i && (wb_adr_i == rd_adr_i) && !adr_zero;

    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if (fwd_hit) begin
            rd_data_o = wb_data_i;
            rd_busy_o = 1'b0;
        end else if (!adr_zero) begin
            rd_data_o = regs_i[rd_adr_i];
            rd_busy_o = busy_i[rd_adr_i];
        end
    end
`else
    always_comb begin
        rd_data_o = '0;
        rd_busy_o = 1'b0;
        if (!adr_zero) begin
            rd_data_o = regs_i[rd_adr_i];
            rd_busy_o = busy_i[rd_adr_i];
        end
    end
`endif

endmodule

// File: rtl/regfile_sb.sv
// Purpose : integer register file with per-register busy scoreboard for decode/issue.
// Latency : reads 0 cycles; write/busy updates visible the cycle after the edge.
// Backpressure: issue_ready_o low while the destination is busy; requester holds.
//
// Ports:
//   clk, reset_n   - clock, asynchronous active-low reset
//   rd_adr_i       - NUM_RD packed read addresses (port p at [p*AW +: AW])
//   rd_data_o      - NUM_RD packed read data      (port p at [p*XLEN +: XLEN])
//   rd_busy_o      - busy flag per read port
//   issue_v_i/issue_adr_i/issue_ready_o - mark a destination busy
//   wb_v_i/wb_adr_i/wb_data_i           - writeback, clears busy
//   flush_i        - clear every busy bit
//
// Optional feature macro: REGFILE_BYPASS_EN adds writeback-to-read forwarding
// and lets a same-cycle writeback make issue_ready_o high.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int XLEN   = XLEN_DEFAULT,
    parameter int DEPTH  = 32,
    parameter int NUM_RD = 2,
    // Derived from DEPTH; do not override.
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_RD*AW-1:0]   rd_adr_i,
    output logic [NUM_RD*XLEN-1:0] rd_data_o,
    output logic [NUM_RD-1:0]      rd_busy_o,
    input  logic                   issue_v_i,
    input  logic [AW-1:0]          issue_adr_i,
    output logic                   issue_ready_o,
    input  logic                   wb_v_i,
    input  logic [AW-1:0]          wb_adr_i,
    input  logic [XLEN-1:0]        wb_data_i,
    input  logic                   flush_i
);

    // ------------------------------------------------------------------
    // Storage: entries 1..DEPTH-1 only; x0 is a constant zero.
    // ------------------------------------------------------------------
    logic [XLEN-1:0]  regs_q    [1:DEPTH-1];
    logic [DEPTH-1:1] busy_q;
    logic [DEPTH-1:1] busy_d;

    // Full-depth views with entry 0 tied to zero, consumed by the read ports.
    logic [XLEN-1:0]  regs_view [DEPTH];
    logic [DEPTH-1:0] busy_view;

    logic wb_we;
    logic issue_acc;
    logic issue_zero;

    assign wb_we      = wb_v_i && !is_zero_reg(32'(wb_adr_i));
    assign issue_zero = is_zero_reg(32'(issue_adr_i));

    assign regs_view[0] = '0;
    assign busy_view    = {busy_q, 1'b0};

    // ------------------------------------------------------------------
    // Issue handshake. Flush does not gate ready, only acceptance, so the
    // squashed requester simply sees its issue dropped.
    // ------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
    assign issue_ready_o = issue_zero || !busy_view[issue_adr_i] ||
                           (wb_v_i && (wb_adr_i == issue_adr_i));
`else
    assign issue_ready_o = issue_zero || !busy_view[issue_adr_i];
`endif

    assign issue_acc = issue_v_i && issue_ready_o && !flush_i;

    // ------------------------------------------------------------------
    // Per-register data and busy bit.
    // Busy priority: flush clears everything, otherwise an accepted issue
    // (younger instruction) beats a writeback to the same register.
    // ------------------------------------------------------------------
    for (genvar i = 1; i < DEPTH; i++) begin : g_entry
        logic wb_hit;
        logic set_hit;

        assign wb_hit  = wb_we && (wb_adr_i == AW'(i));
        assign set_hit = issue_acc && (issue_adr_i == AW'(i));

        assign busy_d[i]    = !flush_i && (set_hit || (busy_q[i] && !wb_hit));
        assign regs_view[i] = regs_q[i];

        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                regs_q[i] <= '0;
                busy_q[i] <= 1'b0;
            end else begin
                if (wb_hit) begin
                    regs_q[i] <= wb_data_i;
                end
                busy_q[i] <= busy_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Read ports.
    // ------------------------------------------------------------------
    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        regfile_rd_port #(
            .XLEN  (XLEN),
            .DEPTH (DEPTH),
            .AW    (AW)
        ) u_rd_port (
            .rd_adr_i  (rd_adr_i[p*AW +: AW]),
            .regs_i    (regs_view),
            .busy_i    (busy_view),
`ifdef REGFILE_BYPASS_EN
            .wb_v_i    (wb_v_i),
            .wb_adr_i  (wb_adr_i),
            .wb_data_i (wb_data_i),
`endif
            .rd_data_o (rd_data_o[p*XLEN +: XLEN]),
            .rd_busy_o (rd_busy_o[p])
        );
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Purpose : self-checking bench for regfile_sb (directed scenarios + random traffic).
// Latency : n/a.
// Backpressure: issue requests honour issue_ready_o as modelled below.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 32;
    localparam int NUM_RD = 2;
    localparam int AW     = 5;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NUM_RD*AW-1:0]   rd_adr_i;
    logic [NUM_RD*XLEN-1:0] rd_data_o;
    logic [NUM_RD-1:0]      rd_busy_o;
    logic                   issue_v_i;
    logic [AW-1:0]          issue_adr_i;
    logic                   issue_ready_o;
    logic                   wb_v_i;
    logic [AW-1:0]          wb_adr_i;
    logic [XLEN-1:0]        wb_data_i;
    logic                   flush_i;

    int total = 0;
    int bad   = 0;

    // Reference state: architectural register values and pending-write marks.
    logic [XLEN-1:0] mreg  [DEPTH];
    bit              mbusy [DEPTH];

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    always #5 clk = ~clk;

    regfile_sb #(
        .XLEN   (XLEN),
        .DEPTH  (DEPTH),
        .NUM_RD (NUM_RD)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rd_adr_i      (rd_adr_i),
        .rd_data_o     (rd_data_o),
        .rd_busy_o     (rd_busy_o),
        .issue_v_i     (issue_v_i),
        .issue_adr_i   (issue_adr_i),
        .issue_ready_o (issue_ready_o),
        .wb_v_i        (wb_v_i),
        .wb_adr_i      (wb_adr_i),
        .wb_data_i     (wb_data_i),
        .flush_i       (flush_i)
    );

    // ---------------- reference model ----------------
    function automatic logic [XLEN-1:0] exp_data(input int a);
        if (a == 0) return '0;
        if (BYPASS && wb_v_i && int'(wb_adr_i) == a) return wb_data_i;
        return mreg[a];
    endfunction

    function automatic bit exp_busy(input int a);
        if (a == 0) return 1'b0;
        if (BYPASS && wb_v_i && int'(wb_adr_i) == a) return 1'b0;
        return mbusy[a];
    endfunction

    function automatic bit exp_ready();
        int a;
        a = int'(issue_adr_i);
        if (a == 0 || !mbusy[a]) return 1'b1;
        if (BYPASS && wb_v_i && int'(wb_adr_i) == a) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge: model consumes the inputs that are present at the edge.
    task automatic tick();
        bit acc;
        int ia, wa;
        acc = issue_v_i && exp_ready() && !flush_i;
        ia  = int'(issue_adr_i);
        wa  = int'(wb_adr_i);
        if (wb_v_i && wa != 0) begin
            mreg[wa]  = wb_data_i;
            mbusy[wa] = 1'b0;
        end
        if (acc && ia != 0) mbusy[ia] = 1'b1;
        if (flush_i) foreach (mbusy[k]) mbusy[k] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        issue_v_i   = 1'b0;
        issue_adr_i = '0;
        wb_v_i      = 1'b0;
        wb_adr_i    = '0;
        wb_data_i   = '0;
        flush_i     = 1'b0;
    endtask

    task automatic set_rd(input int p, input int a);
        rd_adr_i[p*AW +: AW] = AW'(a);
    endtask

    task automatic model_clear();
        foreach (mreg[k]) begin
            mreg[k]  = '0;
            mbusy[k] = 1'b0;
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        idle();
        rd_adr_i = '0;
        reset_n  = 1'b0;
        model_clear();
        #12;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, a);
            set_rd(1, DEPTH - 1 - a);
            issue_adr_i = AW'(a);
            #1;
            total++;
            if (rd_data_o !== '0 || rd_busy_o !== '0) begin
                bad++;
                $display("FAIL reset_read a=%0d: data=%h busy=%b, need 0/0", a, rd_data_o, rd_busy_o);
            end
            total++;
            if (issue_ready_o !== 1'b1) begin
                bad++;
                $display("FAIL reset_ready a=%0d: got %b, need 1", a, issue_ready_o);
            end
        end
        issue_adr_i = '0;
    endtask

    task automatic test_write();
        wb_v_i = 1'b1; wb_adr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
        tick();
        idle();
        set_rd(0, 5); set_rd(1, 5);
        #1;
        for (int p = 0; p < NUM_RD; p++) begin
            total++;
            if (rd_data_o[p*XLEN +: XLEN] !== 32'hDEADBEEF) begin
                bad++;
                $display("FAIL write_r5 port%0d: got %h, need deadbeef", p, rd_data_o[p*XLEN +: XLEN]);
            end
        end
        wb_v_i = 1'b1; wb_adr_i = 5'd0; wb_data_i = 32'h1234;
        tick();
        idle();
        set_rd(0, 0);
        #1;
        total++;
        if (rd_data_o[XLEN-1:0] !== '0 || rd_busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL write_r0: data=%h busy=%b, need 0/0", rd_data_o[XLEN-1:0], rd_busy_o[0]);
        end
    endtask

    task automatic test_issue_block();
        issue_v_i = 1'b1; issue_adr_i = 5'd7;
        #1;
        total++;
        if (issue_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL issue_first_ready: got %b, need 1", issue_ready_o);
        end
        tick();
        set_rd(0, 7);
        #1;
        total++;
        if (issue_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL issue_again_ready: got %b, need 0", issue_ready_o);
        end
        tick();
        issue_v_i = 1'b0;
        #1;
        total++;
        if (rd_busy_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL issue_busy_held: got %b, need 1", rd_busy_o[0]);
        end
        wb_v_i = 1'b1; wb_adr_i = 5'd7; wb_data_i = 32'h55;
        tick();
        idle();
        issue_adr_i = 5'd7;
        #1;
        total++;
        if (rd_busy_o[0] !== 1'b0 || issue_ready_o !== 1'b1 || rd_data_o[XLEN-1:0] !== 32'h55) begin
            bad++;
            $display("FAIL wb_r7: busy=%b ready=%b data=%h, need 0/1/55",
                     rd_busy_o[0], issue_ready_o, rd_data_o[XLEN-1:0]);
        end
        issue_adr_i = '0;
    endtask

    task automatic test_issue_wb_same();
        issue_v_i = 1'b1; issue_adr_i = 5'd9;
        wb_v_i = 1'b1; wb_adr_i = 5'd9; wb_data_i = 32'hA5;
        tick();
        idle();
        set_rd(1, 9);
        #1;
        total++;
        if (rd_data_o[XLEN +: XLEN] !== 32'hA5 || rd_busy_o[1] !== 1'b1) begin
            bad++;
            $display("FAIL issue_wb_same: data=%h busy=%b, need a5/1", rd_data_o[XLEN +: XLEN], rd_busy_o[1]);
        end
    endtask

    task automatic test_flush();
        int regs_to_issue [3] = '{3, 4, 6};
        foreach (regs_to_issue[k]) begin
            issue_v_i = 1'b1; issue_adr_i = AW'(regs_to_issue[k]);
            tick();
        end
        issue_v_i = 1'b0;
        set_rd(0, 4);
        #1;
        total++;
        if (rd_busy_o[0] !== 1'b1) begin
            bad++;
            $display("FAIL flush_pre_busy r4: got %b, need 1", rd_busy_o[0]);
        end
        issue_v_i = 1'b1; issue_adr_i = 5'd8; flush_i = 1'b1;
        #1;
        total++;
        if (issue_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_ready_unaffected: got %b, need 1", issue_ready_o);
        end
        tick();
        idle();
        for (int a = 0; a < DEPTH; a++) begin
            set_rd(0, a);
            #1;
            total++;
            if (rd_busy_o[0] !== 1'b0) begin
                bad++;
                $display("FAIL flush_busy a=%0d: got %b, need 0", a, rd_busy_o[0]);
            end
        end
        issue_adr_i = 5'd8;
        #1;
        total++;
        if (issue_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_r8_ready: got %b, need 1", issue_ready_o);
        end
        issue_adr_i = '0;
    endtask

    task automatic test_bypass();
        logic [XLEN-1:0] want_d;
        bit              want_b;
        bit              want_r;
        wb_v_i = 1'b1; wb_adr_i = 5'd10; wb_data_i = 32'h1111;
        tick();
        idle();
        issue_v_i = 1'b1; issue_adr_i = 5'd10;
        tick();
        idle();
        set_rd(0, 10);
        issue_adr_i = 5'd10;
        wb_v_i = 1'b1; wb_adr_i = 5'd10; wb_data_i = 32'hCAFE;
        #1;
        want_d = BYPASS ? 32'hCAFE : 32'h1111;
        want_b = BYPASS ? 1'b0 : 1'b1;
        want_r = BYPASS ? 1'b1 : 1'b0;
        total++;
        if (rd_data_o[XLEN-1:0] !== want_d || rd_busy_o[0] !== want_b) begin
            bad++;
            $display("FAIL bypass_read: data=%h busy=%b, need %h/%b",
                     rd_data_o[XLEN-1:0], rd_busy_o[0], want_d, want_b);
        end
        total++;
        if (issue_ready_o !== want_r) begin
            bad++;
            $display("FAIL bypass_ready: got %b, need %b", issue_ready_o, want_r);
        end
        tick();
        idle();
        #1;
        total++;
        if (rd_data_o[XLEN-1:0] !== 32'hCAFE || rd_busy_o[0] !== 1'b0) begin
            bad++;
            $display("FAIL bypass_after: data=%h busy=%b, need cafe/0", rd_data_o[XLEN-1:0], rd_busy_o[0]);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            issue_v_i   = ($urandom_range(0, 99) < 50);
            issue_adr_i = AW'($urandom_range(0, 7));
            wb_v_i      = ($urandom_range(0, 99) < 45);
            wb_adr_i    = AW'($urandom_range(0, 7));
            wb_data_i   = $urandom;
            flush_i     = ($urandom_range(0, 99) < 5);
            for (int p = 0; p < NUM_RD; p++) set_rd(p, $urandom_range(0, 9));
            #1;
            for (int p = 0; p < NUM_RD; p++) begin
                int a;
                a = int'(rd_adr_i[p*AW +: AW]);
                total++;
                if (rd_data_o[p*XLEN +: XLEN] !== exp_data(a) || rd_busy_o[p] !== exp_busy(a)) begin
                    bad++;
                    $display("FAIL rand_read c=%0d p=%0d a=%0d: data=%h busy=%b, need %h/%b",
                             c, p, a, rd_data_o[p*XLEN +: XLEN], rd_busy_o[p], exp_data(a), exp_busy(a));
                end
            end
            total++;
            if (issue_ready_o !== exp_ready()) begin
                bad++;
                $display("FAIL rand_ready c=%0d adr=%0d: got %b, need %b",
                         c, issue_adr_i, issue_ready_o, exp_ready());
            end
            tick();
        end
        idle();
    endtask

    task automatic test_async_reset();
        wb_v_i = 1'b1; wb_adr_i = 5'd12; wb_data_i = 32'h77;
        tick();
        idle();
        issue_v_i = 1'b1; issue_adr_i = 5'd12;
        tick();
        idle();
        set_rd(0, 12);
        issue_adr_i = 5'd12;
        #2;
        // Reset asserted between clock edges must take effect immediately.
        reset_n = 1'b0;
        model_clear();
        #1;
        total++;
        if (rd_data_o[XLEN-1:0] !== '0 || rd_busy_o[0] !== 1'b0 || issue_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL async_reset: data=%h busy=%b ready=%b, need 0/0/1",
                     rd_data_o[XLEN-1:0], rd_busy_o[0], issue_ready_o);
        end
        @(posedge clk);
        #1 reset_n = 1'b1;
        issue_adr_i = '0;
    endtask

    initial begin
        test_reset();
        test_write();
        test_issue_block();
        test_issue_wb_same();
        test_flush();
        test_bypass();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
